dense_output_layer: RTL and testbench
=====================================

# dense_output_layer

Fully-connected output stage of the digit-recognition datapath. On `start` it computes N_OUT signed class scores as bias plus the dot product of an N_IN-element activation vector with one weight row per class. Activations, weights and biases are read from synchronous memories. Each score is written into the score RAM that the downstream arg-max stage scans at addresses 0..N_OUT-1. `done` tells the arg-max stage that all scores are valid.

## Interface
Parameters:
- N_IN, 784: activations per dot product (28×28 pixels)
- N_OUT, 10: output neurons / class scores
- FRAC, 8: fractional bits of activations and weights (Q7.8)
- ACC_W, 48: accumulator width
- RELU, 0: 1 clamps negative results to 0 before write

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high
- start  in  1  begin one layer evaluation; sampled only in IDLE
- act_addr  out  14  activation memory address (= i)
- act_data  in  16  signed activation, valid the cycle after act_addr
- w_addr  out  14  weight memory address (= j*N_IN + i)
- w_data  in  16  signed weight, valid the cycle after w_addr
- b_addr  out  4  bias memory address (= j)
- b_data  in  32  signed bias, Q·2FRAC (16 fractional bits), valid the cycle after b_addr
- out_addr  out  14  score RAM write address (= j)
- out_data  out  32  signed score, Q·FRAC
- out_we  out  1  score RAM write strobe
- done  out  1  one-cycle pulse after the last score write

## Operation
- States: IDLE, BIAS, MAC, WRITE, DONE.
- IDLE: with start=1, clear j←0, i←0 and go to BIAS. Otherwise hold.
- BIAS (1 cycle): drive b_addr=j, act_addr=0, w_addr=j*N_IN. Go to MAC.
- MAC (N_IN+1 cycles):
  - First cycle: acc←sign-extend(b_data).
  - Each following cycle: acc←acc + act_data*w_data, using the 32-bit signed product of the data addressed in the previous cycle.
  - Addresses i advance 1..N_IN-1 in lockstep, so one term is accumulated per cycle.
  - After the N_IN-th product is accumulated, go to WRITE.
- WRITE (1 cycle):
  - out_we=1, out_addr=j.
  - out_data = saturate32(acc >>> FRAC), using an arithmetic shift. Results above 2^31-1 become 0x7FFFFFFF; results below -2^31 become 0x80000000.
  - If RELU=1, negative results become 0.
  - If j==N_OUT-1, go to DONE. Otherwise set j←j+1, i←0 and go to BIAS.
- DONE (1 cycle): done=1, then go to IDLE.
- start is ignored outside IDLE. A start held high in IDLE after DONE begins a new run.
- Accumulator arithmetic is in ACC_W bits. No wrap is possible for the defaults; saturation is applied only at write time.
- Reset in any state:
  - Next state is IDLE; counters are cleared; acc←0.
  - out_we=0 and done=0 from the cycle after Reset is sampled.
  - A partially computed score is never written.

## Timing
- Reset values of outputs: all addresses 0, out_data 0, out_we 0, done 0.
- Per neuron: N_IN+3 cycles (1 BIAS, N_IN+1 MAC, 1 WRITE).
- start sampled at edge e0 → first out_we high in cycle e0+N_IN+3. The last write occurs N_OUT*(N_IN+3) cycles after e0. done is high the following cycle, so total latency is N_OUT*(N_IN+3)+1 cycles (7871 for defaults).
- Score writes are strictly ordered j=0..N_OUT-1, one per neuron, never back-to-back.
- The memory contract is 1-cycle read latency with no stalls. Addresses are registered outputs.

## Structure
- Shared package `nn_pkg`:
  - typedef for the state enum;
  - ACT_W=16, SCORE_W=32 and ADDR_W=14 constants;
  - a `sat32` function for the shift-and-saturate used in WRITE.
- Sub-module `mac_unit`: signed 16×16 multiply plus ACC_W accumulate, with load-bias and accumulate-enable controls. It is reusable by the hidden layer.
- All control (FSM, i/j counters, address generation) lives in the top module.

## Test plan
- N_IN=4, N_OUT=2, all activations 256 (1.0), all weights 256, biases 0 → out_data 1024 at addresses 0 and 1; done exactly 15 cycles after start.
- N_IN=4: bias[0]=0x00010000 (1.0), weights −256, activations 512 (2.0) → score[0] = −1792 (−7.0). With RELU=1 → 0.
- Defaults, all activations and weights 32767 → every score 0x7FFFFFFF. All activations 32767 and weights −32768 → every score 0x80000000.
- Defaults, full run with random memories → 10 writes match a golden model bit-exactly; done one cycle after the 10th write; start pulses during the run are ignored.
- Reset asserted during MAC of neuron 5 → out_we and done stay 0. A fresh start then produces scores identical to an uninterrupted run.
- start held high continuously → back-to-back runs, each with its done pulse, and an IDLE cycle between DONE and the next BIAS.

Source files
------------

// File: rtl/dense_output_layer_pkg.sv
// Shared definitions for the neural-network datapath blocks: FSM state
// encoding, datapath widths and the score shift-and-saturate helper.
package nn_pkg;

  localparam int ACT_W    = 16;  // activation / weight width (Q7.8)
  localparam int SCORE_W  = 32;  // score width written to the score RAM
  localparam int ADDR_W   = 14;  // activation / weight / score address width
  localparam int BIAS_W   = 32;  // bias width (16 fractional bits)
  localparam int BADDR_W  = 4;   // bias address width, also the neuron index width
  localparam int SAT_IN_W = 64;  // accumulators are widened to this before saturation

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BIAS  = 3'd1,
    MAC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

  // Arithmetic right shift by the fractional width, then clamp into 32 bits.
  function automatic logic signed [SCORE_W-1:0] sat32(input logic signed [SAT_IN_W-1:0] acc,
                                                     input int unsigned frac);
    logic signed [SAT_IN_W-1:0] shifted;
    shifted = acc >>> frac;
    if (shifted > SAT_MAX) begin
      sat32 = 32'sh7FFF_FFFF;
    end else if (shifted < SAT_MIN) begin
      sat32 = 32'sh8000_0000;
    end else begin
      sat32 = shifted[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dense_output_layer_if.sv
// Bus bundle between the dense output layer and its memories / arg-max stage.
//
// Protocol: start is a level sampled only while the layer is idle; done is a
// single-cycle pulse after the last score write. The activation, weight and
// bias memories are plain synchronous reads: an address driven in cycle n
// yields data in cycle n+1, with no stall or valid/ready back-pressure. The
// score RAM accepts a write in every cycle out_we is high.
interface dense_output_layer_if;
  import nn_pkg::*;

  logic                      start;
  logic [ADDR_W-1:0]         act_addr;
  logic signed [ACT_W-1:0]   act_data;
  logic [ADDR_W-1:0]         w_addr;
  logic signed [ACT_W-1:0]   w_data;
  logic [BADDR_W-1:0]        b_addr;
  logic signed [BIAS_W-1:0]  b_data;
  logic [ADDR_W-1:0]         out_addr;
  logic [SCORE_W-1:0]        out_data;
  logic                      out_we;
  logic                      done;

  modport master (
    input  start, act_data, w_data, b_data,
    output act_addr, w_addr, b_addr, out_addr, out_data, out_we, done
  );

  modport slave (
    output start, act_data, w_data, b_data,
    input  act_addr, w_addr, b_addr, out_addr, out_data, out_we, done
  );

endinterface

// File: rtl/dense_output_layer_mac.sv
// Signed 16x16 multiply with a registered product feeding a wide accumulator.
// load replaces the accumulator with the sign-extended bias; en adds the
// product registered on the previous cycle.
module mac_unit
  import nn_pkg::*;
#(
  parameter int ACC_W = 48
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     load,
  input  logic                     en,
  input  logic signed [ACT_W-1:0]  a,
  input  logic signed [ACT_W-1:0]  b,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*ACT_W-1:0] prod_q;

  // Register the product every cycle; load wins over accumulate.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prod_q <= '0;
      acc    <= '0;
    end else begin
      prod_q <= a * b;
      if (load) begin
        acc <= ACC_W'(bias);
      end else if (en) begin
        acc <= acc + ACC_W'(prod_q);
      end
    end
  end

endmodule

// File: rtl/dense_output_layer.sv
// Fully-connected output layer: for each class j, score = bias[j] + sum over i
// of act[i]*w[j*N_IN+i], shifted back to Q.FRAC, saturated and written to the
// score RAM at address j. Control and address generation live here; the
// arithmetic is in mac_unit.
module dense_output_layer
  import nn_pkg::*;
#(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int FRAC  = 8,
  parameter int ACC_W = 48,
  parameter int RELU  = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  dense_output_layer_if.master bus,
  output state_t           dbg_state
);

  localparam logic [ADDR_W-1:0]  LAST_I   = ADDR_W'(N_IN - 1);
  localparam logic [ADDR_W-1:0]  MAC_END  = ADDR_W'(N_IN);
  localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(N_IN);
  localparam logic [BADDR_W-1:0] LAST_J   = BADDR_W'(N_OUT - 1);

  state_t                    state_q, state_d;
  logic [BADDR_W-1:0]        j_q;
  logic [ADDR_W-1:0]         i_q;
  logic [ADDR_W-1:0]         w_addr_q;
  logic [ADDR_W-1:0]         w_row_q;
  logic [ADDR_W-1:0]         mac_cnt_q;
  logic                      mac_load, mac_en, write_en, done_pulse;
  logic signed [ACC_W-1:0]   acc;
  logic signed [SCORE_W-1:0] score;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-state strobes. MAC cycle 0 loads the bias, cycles
  // 1..N_IN each add one product from the one-deep product pipeline.
  always_comb begin
    state_d    = state_q;
    mac_load   = 1'b0;
    mac_en     = 1'b0;
    write_en   = 1'b0;
    done_pulse = 1'b0;
    case (state_q)
      IDLE:  if (bus.start) state_d = BIAS;
      BIAS:  state_d = MAC;
      MAC: begin
        if (mac_cnt_q == '0) mac_load = 1'b1;
        else                 mac_en   = 1'b1;
        if (mac_cnt_q == MAC_END) state_d = WRITE;
      end
      WRITE: begin
        write_en = 1'b1;
        state_d  = (j_q == LAST_J) ? DONE : BIAS;
      end
      DONE: begin
        done_pulse = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Neuron / element counters and registered memory addresses. The element
  // address runs one ahead of the MAC cycle so data lands in time for the
  // product register, and parks at N_IN-1 for the final cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      j_q       <= '0;
      i_q       <= '0;
      w_addr_q  <= '0;
      w_row_q   <= '0;
      mac_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            j_q       <= '0;
            i_q       <= '0;
            w_addr_q  <= '0;
            w_row_q   <= '0;
            mac_cnt_q <= '0;
          end
        end
        BIAS, MAC: begin
          if (i_q != LAST_I) begin
            i_q      <= i_q + ADDR_W'(1);
            w_addr_q <= w_addr_q + ADDR_W'(1);
          end
          if (state_q == MAC) mac_cnt_q <= mac_cnt_q + ADDR_W'(1);
          else                mac_cnt_q <= '0;
        end
        WRITE: begin
          if (j_q != LAST_J) begin
            j_q       <= j_q + BADDR_W'(1);
            i_q       <= '0;
            w_row_q   <= w_row_q + ROW_STEP;
            w_addr_q  <= w_row_q + ROW_STEP;
            mac_cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  mac_unit #(.ACC_W(ACC_W)) u_mac (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (mac_load),
    .en    (mac_en),
    .a     (bus.act_data),
    .b     (bus.w_data),
    .bias  (bus.b_data),
    .acc   (acc)
  );

  // Final score: back to Q.FRAC with saturation, optional ReLU clamp.
  always_comb begin
    score = sat32(SAT_IN_W'(acc), FRAC);
    if (RELU != 0 && score[SCORE_W-1]) score = '0;
  end

  assign bus.act_addr = i_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.b_addr   = j_q;
  assign bus.out_addr = ADDR_W'(j_q);
  assign bus.out_we   = write_en;
  assign bus.out_data = write_en ? score : '0;
  assign bus.done     = done_pulse;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dense_output_layer.sv
// Directed bench for dense_output_layer: a small 4x2 instance (plain and ReLU)
// and a default-sized 784x10 instance with synchronous memory models.
module tb_dense_output_layer;
  import nn_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic Reset = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  dense_output_layer_if ia();
  dense_output_layer_if ib();
  dense_output_layer_if ic();
  state_t st_a, st_b, st_c;

  dense_output_layer #(.N_IN(4), .N_OUT(2), .FRAC(8), .ACC_W(48), .RELU(0)) u_a (
    .Clk(clk), .Reset(Reset), .bus(ia), .dbg_state(st_a));
  dense_output_layer #(.N_IN(4), .N_OUT(2), .FRAC(8), .ACC_W(48), .RELU(1)) u_b (
    .Clk(clk), .Reset(Reset), .bus(ib), .dbg_state(st_b));
  dense_output_layer u_c (
    .Clk(clk), .Reset(Reset), .bus(ic), .dbg_state(st_c));

  // ---------------- memory models (1-cycle read latency) ----------------
  logic signed [15:0] act_a [0:16383];
  logic signed [15:0] w_a   [0:16383];
  logic signed [31:0] b_a   [0:15];
  logic signed [15:0] act_b [0:16383];
  logic signed [15:0] w_b   [0:16383];
  logic signed [31:0] b_b   [0:15];
  logic signed [15:0] act_c [0:16383];
  logic signed [15:0] w_c   [0:16383];
  logic signed [31:0] b_c   [0:15];

  always @(posedge clk) begin
    ia.act_data <= act_a[ia.act_addr];
    ia.w_data   <= w_a[ia.w_addr];
    ia.b_data   <= b_a[ia.b_addr];
    ib.act_data <= act_b[ib.act_addr];
    ib.w_data   <= w_b[ib.w_addr];
    ib.b_data   <= b_b[ib.b_addr];
    ic.act_data <= act_c[ic.act_addr];
    ic.w_data   <= w_c[ic.w_addr];
    ic.b_data   <= b_c[ic.b_addr];
  end

  // ---------------- score RAM monitors ----------------
  int          wa_addr[$], wa_cyc[$], da_cyc[$];
  logic [31:0] wa_data[$];
  int          wb_addr[$], wb_cyc[$], db_cyc[$];
  logic [31:0] wb_data[$];
  int          wc_addr[$], wc_cyc[$], dc_cyc[$];
  logic [31:0] wc_data[$];

  always @(negedge clk) begin
    if (ia.out_we === 1'b1) begin
      wa_addr.push_back(int'(ia.out_addr)); wa_data.push_back(ia.out_data); wa_cyc.push_back(cyc);
    end
    if (ia.done === 1'b1) da_cyc.push_back(cyc);
    if (ib.out_we === 1'b1) begin
      wb_addr.push_back(int'(ib.out_addr)); wb_data.push_back(ib.out_data); wb_cyc.push_back(cyc);
    end
    if (ib.done === 1'b1) db_cyc.push_back(cyc);
    if (ic.out_we === 1'b1) begin
      wc_addr.push_back(int'(ic.out_addr)); wc_data.push_back(ic.out_data); wc_cyc.push_back(cyc);
    end
    if (ic.done === 1'b1) dc_cyc.push_back(cyc);
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  // Reference score for the default-sized instance, in 64-bit integers.
  function automatic logic [31:0] model_c(input int j);
    longint acc;
    longint s;
    acc = longint'(b_c[j]);
    for (int i = 0; i < 784; i++) acc += longint'(act_c[i]) * longint'(w_c[j*784+i]);
    s = acc >>> 8;
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic int done_count(input int which);
    if (which == 0) return da_cyc.size();
    if (which == 1) return db_cyc.size();
    return dc_cyc.size();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_q();
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete(); da_cyc.delete();
    wb_addr.delete(); wb_data.delete(); wb_cyc.delete(); db_cyc.delete();
    wc_addr.delete(); wc_data.delete(); wc_cyc.delete(); dc_cyc.delete();
    exp_q.delete();
  endtask

  // Pulse start for one edge; s is the cycle number of the first cycle after
  // the sampling edge (cycle 1 of the run).
  task automatic start_run(input int which, output int s);
    @(negedge clk); #1;
    if (which == 0) ia.start = 1'b1;
    else if (which == 1) begin ia.start = 1'b1; ib.start = 1'b1; end
    else ic.start = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (done_count(which) >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic fill_c(input logic signed [15:0] av, input logic signed [15:0] wv);
    for (int i = 0; i < 784; i++) act_c[i] = av;
    for (int k = 0; k < 7840; k++) w_c[k] = wv;
    for (int j = 0; j < 10; j++) b_c[j] = 32'sd0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (ia.act_addr !== '0) begin n_fail++; $display("FAIL reset_act_addr: got %0d want 0", ia.act_addr); end
    n_checks++; if (ia.w_addr !== '0) begin n_fail++; $display("FAIL reset_w_addr: got %0d want 0", ia.w_addr); end
    n_checks++; if (ia.b_addr !== '0) begin n_fail++; $display("FAIL reset_b_addr: got %0d want 0", ia.b_addr); end
    n_checks++; if (ia.out_addr !== '0) begin n_fail++; $display("FAIL reset_out_addr: got %0d want 0", ia.out_addr); end
    n_checks++; if (ia.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", ia.out_data); end
    n_checks++; if (ia.out_we !== 1'b0) begin n_fail++; $display("FAIL reset_out_we: got %b want 0", ia.out_we); end
    n_checks++; if (ia.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ia.done); end
    n_checks++; if (st_a !== IDLE) begin n_fail++; $display("FAIL reset_state_a: got %0d want IDLE", st_a); end
    n_checks++; if (ic.out_we !== 1'b0) begin n_fail++; $display("FAIL reset_out_we_c: got %b want 0", ic.out_we); end
    n_checks++; if (ic.w_addr !== '0) begin n_fail++; $display("FAIL reset_w_addr_c: got %0d want 0", ic.w_addr); end
    n_checks++; if (st_c !== IDLE) begin n_fail++; $display("FAIL reset_state_c: got %0d want IDLE", st_c); end
    Reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // 4 terms of 1.0*1.0, zero bias: each score 4.0 = 1024, done on cycle 15.
  task automatic test_basic();
    int s;
    bit ok;
    for (int i = 0; i < 4; i++) act_a[i] = 16'sd256;
    for (int k = 0; k < 8; k++) w_a[k] = 16'sd256;
    b_a[0] = 32'sd0; b_a[1] = 32'sd0;
    clear_q();
    exp_q.push_back(32'd1024); exp_q.push_back(32'd1024);
    start_run(0, s);
    wait_done(0, 1, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done in 100 cycles, want done"); end
    n_checks++; if (wa_data.size() != 2) begin n_fail++; $display("FAIL basic_write_count: got %0d want 2", wa_data.size()); end
    for (int k = 0; k < wa_data.size() && k < 2; k++) begin
      n_checks++; if (wa_addr[k] != k) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d want %0d", k, wa_addr[k], k); end
      n_checks++; if (wa_data[k] !== exp_q[k]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", k, wa_data[k], exp_q[k]); end
      n_checks++; if (wa_cyc[k] - s + 1 != 7 * (k + 1)) begin n_fail++; $display("FAIL basic_write_cycle[%0d]: got %0d want %0d", k, wa_cyc[k] - s + 1, 7 * (k + 1)); end
    end
    if (da_cyc.size() > 0) begin
      n_checks++; if (da_cyc[0] - s + 1 != 15) begin n_fail++; $display("FAIL basic_done_latency: got %0d want 15", da_cyc[0] - s + 1); end
    end
  endtask

  // bias 1.0 + 4*(2.0*-1.0) = -7.0 -> -1792; neuron 1 has zero bias: -8.0 -> -2048.
  // The ReLU instance sees the same data and must write zeros.
  task automatic test_bias_relu();
    int s;
    bit ok;
    for (int i = 0; i < 4; i++) begin act_a[i] = 16'sd512; act_b[i] = 16'sd512; end
    for (int k = 0; k < 8; k++) begin w_a[k] = -16'sd256; w_b[k] = -16'sd256; end
    b_a[0] = 32'sh0001_0000; b_a[1] = 32'sd0;
    b_b[0] = 32'sh0001_0000; b_b[1] = 32'sd0;
    clear_q();
    exp_q.push_back(32'hFFFF_F900); exp_q.push_back(32'hFFFF_F800);
    start_run(1, s);
    wait_done(1, 1, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL relu_timeout: got no done in 100 cycles, want done"); end
    n_checks++; if (wa_data.size() != 2) begin n_fail++; $display("FAIL bias_write_count: got %0d want 2", wa_data.size()); end
    n_checks++; if (wb_data.size() != 2) begin n_fail++; $display("FAIL relu_write_count: got %0d want 2", wb_data.size()); end
    for (int k = 0; k < wa_data.size() && k < 2; k++) begin
      n_checks++; if (wa_data[k] !== exp_q[k]) begin n_fail++; $display("FAIL bias_data[%0d]: got %h want %h", k, wa_data[k], exp_q[k]); end
    end
    for (int k = 0; k < wb_data.size() && k < 2; k++) begin
      n_checks++; if (wb_data[k] !== 32'd0) begin n_fail++; $display("FAIL relu_data[%0d]: got %h want 0", k, wb_data[k]); end
      n_checks++; if (wb_addr[k] != k) begin n_fail++; $display("FAIL relu_addr[%0d]: got %0d want %0d", k, wb_addr[k], k); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturation();
    int s;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      clear_q();
      if (pass == 0) fill_c(16'sd32767, 16'sd32767);
      else           fill_c(16'sd32767, -16'sd32768);
      for (int j = 0; j < 10; j++) exp_q.push_back(pass == 0 ? 32'h7FFF_FFFF : 32'h8000_0000);
      start_run(2, s);
      wait_done(2, 1, 8000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL sat%0d_timeout: got no done in 8000 cycles, want done", pass); end
      n_checks++; if (wc_data.size() != 10) begin n_fail++; $display("FAIL sat%0d_write_count: got %0d want 10", pass, wc_data.size()); end
      for (int k = 0; k < wc_data.size() && k < 10; k++) begin
        n_checks++; if (wc_data[k] !== exp_q[k]) begin n_fail++; $display("FAIL sat%0d_data[%0d]: got %h want %h", pass, k, wc_data[k], exp_q[k]); end
      end
      repeat (3) @(negedge clk);
    end
  endtask

  // Random memories against the reference model; stray start pulses mid-run.
  task automatic test_random();
    int s;
    bit ok;
    for (int i = 0; i < 784; i++) act_c[i] = 16'($urandom_range(0, 65535));
    for (int k = 0; k < 7840; k++) w_c[k] = 16'($urandom_range(0, 65535));
    for (int j = 0; j < 10; j++) b_c[j] = 32'($urandom);
    clear_q();
    for (int j = 0; j < 10; j++) exp_q.push_back(model_c(j));
    start_run(2, s);
    ok = 1'b0;
    for (int k = 1; k <= 8000; k++) begin
      @(negedge clk); #1;
      ic.start = (k == 100 || k == 3000 || k == 7860);
      if (dc_cyc.size() >= 1) begin ok = 1'b1; break; end
    end
    ic.start = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: got no done in 8000 cycles, want done"); end
    n_checks++; if (wc_data.size() != 10) begin n_fail++; $display("FAIL rand_write_count: got %0d want 10", wc_data.size()); end
    for (int k = 0; k < wc_data.size() && k < 10; k++) begin
      n_checks++; if (wc_addr[k] != k) begin n_fail++; $display("FAIL rand_addr[%0d]: got %0d want %0d", k, wc_addr[k], k); end
      n_checks++; if (wc_data[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", k, wc_data[k], exp_q[k]); end
      n_checks++; if (wc_cyc[k] - s + 1 != 787 * (k + 1)) begin n_fail++; $display("FAIL rand_write_cycle[%0d]: got %0d want %0d", k, wc_cyc[k] - s + 1, 787 * (k + 1)); end
    end
    if (dc_cyc.size() > 0 && wc_cyc.size() > 0) begin
      n_checks++; if (dc_cyc[0] - s + 1 != 7871) begin n_fail++; $display("FAIL rand_done_latency: got %0d want 7871", dc_cyc[0] - s + 1); end
      n_checks++; if (dc_cyc[0] - wc_cyc[wc_cyc.size()-1] != 1) begin n_fail++; $display("FAIL rand_done_after_write: got %0d want 1", dc_cyc[0] - wc_cyc[wc_cyc.size()-1]); end
    end
    repeat (20) @(negedge clk);
    #1;
    n_checks++; if (wc_data.size() != 10) begin n_fail++; $display("FAIL rand_no_restart: got %0d writes want 10", wc_data.size()); end
    n_checks++; if (st_c !== IDLE) begin n_fail++; $display("FAIL rand_idle: got state %0d want IDLE", st_c); end
  endtask

  // Reset during neuron 5's MAC phase, then a clean rerun on the same data.
  task automatic test_reset_mid_run();
    int s;
    bit ok;
    clear_q();
    for (int j = 0; j < 10; j++) exp_q.push_back(model_c(j));
    start_run(2, s);
    for (int k = 0; k < 4199; k++) begin @(negedge clk); #1; end
    n_checks++; if (st_c !== MAC) begin n_fail++; $display("FAIL mid_state: got %0d want MAC", st_c); end
    n_checks++; if (wc_data.size() != 5) begin n_fail++; $display("FAIL mid_writes_before_reset: got %0d want 5", wc_data.size()); end
    wc_addr.delete(); wc_data.delete(); wc_cyc.delete(); dc_cyc.delete();
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_checks++; if (ic.out_we !== 1'b0) begin n_fail++; $display("FAIL mid_reset_we[%0d]: got %b want 0", k, ic.out_we); end
      n_checks++; if (ic.done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done[%0d]: got %b want 0", k, ic.done); end
    end
    Reset = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    n_checks++; if (wc_data.size() != 0) begin n_fail++; $display("FAIL mid_partial_write: got %0d writes want 0", wc_data.size()); end
    n_checks++; if (dc_cyc.size() != 0) begin n_fail++; $display("FAIL mid_spurious_done: got %0d want 0", dc_cyc.size()); end
    n_checks++; if (st_c !== IDLE) begin n_fail++; $display("FAIL mid_idle: got %0d want IDLE", st_c); end
    start_run(2, s);
    wait_done(2, 1, 8000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rerun_timeout: got no done in 8000 cycles, want done"); end
    n_checks++; if (wc_data.size() != 10) begin n_fail++; $display("FAIL rerun_write_count: got %0d want 10", wc_data.size()); end
    for (int k = 0; k < wc_data.size() && k < 10; k++) begin
      n_checks++; if (wc_data[k] !== exp_q[k]) begin n_fail++; $display("FAIL rerun_data[%0d]: got %h want %h", k, wc_data[k], exp_q[k]); end
    end
    if (dc_cyc.size() > 0) begin
      n_checks++; if (dc_cyc[0] - s + 1 != 7871) begin n_fail++; $display("FAIL rerun_done_latency: got %0d want 7871", dc_cyc[0] - s + 1); end
    end
  endtask

  // start held high: two runs separated by one IDLE cycle.
  task automatic test_back_to_back();
    int s;
    bit ok;
    for (int i = 0; i < 4; i++) act_a[i] = 16'sd256;
    for (int k = 0; k < 8; k++) w_a[k] = 16'sd256;
    b_a[0] = 32'sd0; b_a[1] = 32'sd0;
    clear_q();
    @(negedge clk); #1;
    ia.start = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    wait_done(0, 2, 100, ok);
    ia.start = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got %0d done pulses want 2", da_cyc.size()); end
    repeat (20) @(negedge clk);
    #1;
    n_checks++; if (wa_data.size() != 4) begin n_fail++; $display("FAIL b2b_write_count: got %0d want 4", wa_data.size()); end
    for (int k = 0; k < wa_data.size() && k < 4; k++) begin
      n_checks++; if (wa_data[k] !== 32'd1024) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want 00000400", k, wa_data[k]); end
      n_checks++; if (wa_addr[k] != k % 2) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", k, wa_addr[k], k % 2); end
    end
    n_checks++; if (da_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", da_cyc.size()); end
    if (da_cyc.size() >= 2 && wa_cyc.size() >= 3) begin
      n_checks++; if (da_cyc[0] - s + 1 != 15) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 15", da_cyc[0] - s + 1); end
      n_checks++; if (da_cyc[1] - da_cyc[0] != 16) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d want 16", da_cyc[1] - da_cyc[0]); end
      n_checks++; if (wa_cyc[2] - da_cyc[0] != 8) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d want 8", wa_cyc[2] - da_cyc[0]); end
    end
    n_checks++; if (st_a !== IDLE) begin n_fail++; $display("FAIL b2b_idle: got %0d want IDLE", st_a); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    ia.start = 1'b0;
    ib.start = 1'b0;
    ic.start = 1'b0;
    test_reset();
    test_basic();
    test_bias_relu();
    test_saturation();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
